wb_stage: RTL and testbench

- Writeback stage that sits directly upstream of the 8-bit register file and drives its WriteEn/Waddr/DataIn write port.
- Accepts retiring instructions from the memory stage through a valid/ready handshake.
- ALU results are written with a fixed 1-cycle latency. Loads wait for data-memory read data, with a bounded timeout.
- Also provides a sticky load-error flag and a retired-write counter for debug.

---
 rtl/wb_stage.sv | 142 ++++++++++++++
 tb/tb_wb_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage feeding the register-file write port.
// ALU results retire with a fixed one-cycle latency; loads park in WAIT_LD
// until data memory returns read data or a bounded timeout expires.
module wb_stage #(
  parameter int W       = 8,
  parameter int A       = 3,
  parameter int TIMEOUT = 16
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         InValid,
  output logic         InReady,
  input  logic [A-1:0] InDst,
  input  logic         InRegWrite,
  input  logic         InIsLoad,
  input  logic [W-1:0] InAluResult,
  input  logic         MemRdValid,
  input  logic [W-1:0] MemRdData,
  output logic         WriteEn,
  output logic [A-1:0] Waddr,
  output logic [W-1:0] DataIn,
  output logic         LdErr,
  input  logic         ErrClr,
  output logic [15:0]  RetireCnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_LD = 1'b1
  } state_t;

  // Last legal timeout-counter value; the load is abandoned in the cycle the
  // counter holds this value and no read data shows up.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t         state;
  state_t         state_nxt;
  logic [7:0]     to_cnt;
  logic [A-1:0]   cap_dst;
  logic           cap_regwrite;

  logic           accept;
  logic           alu_wr;
  logic           ld_accept;
  logic           ld_done;
  logic           ld_timeout;

  // Handshake and event decode shared by the FSM and the datapath.
  assign accept     = InValid & InReady;
  assign alu_wr     = accept & ~InIsLoad & InRegWrite;
  assign ld_accept  = accept & InIsLoad;
  // Read data is only meaningful while a load is outstanding; in IDLE it is
  // ignored, even in the very cycle the load is accepted.
  assign ld_done    = (state == WAIT_LD) & MemRdValid;
  // Read data in the terminal-count cycle takes priority over the timeout.
  assign ld_timeout = (state == WAIT_LD) & ~MemRdValid & (to_cnt == TO_LAST);

  // State register.
  // NOTE: reset is in the sensitivity list so it asserts without a clock edge;
  // every flop below follows the same pattern.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (ld_accept) state_nxt = WAIT_LD;
      WAIT_LD: if (ld_done || ld_timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: the stage only accepts while no load is outstanding.
  always_comb begin
    InReady = (state == IDLE);
  end

  // Load bookkeeping: capture the destination on accept and count wait cycles.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cap_dst      <= '0;
      cap_regwrite <= 1'b0;
      to_cnt       <= '0;
    end else if (ld_accept) begin
      cap_dst      <= InDst;
      cap_regwrite <= InRegWrite;
      to_cnt       <= '0;
    end else if (state == WAIT_LD) begin
      to_cnt       <= to_cnt + 8'd1;
    end
  end

  // Register-file write port; address and data hold when nothing retires.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      WriteEn <= 1'b0;
      Waddr   <= '0;
      DataIn  <= '0;
    end else if (alu_wr) begin
      WriteEn <= 1'b1;
      Waddr   <= InDst;
      DataIn  <= InAluResult;
    end else if (ld_done) begin
      WriteEn <= cap_regwrite;
      Waddr   <= cap_dst;
      DataIn  <= MemRdData;
    end else begin
      WriteEn <= 1'b0;
    end
  end

  // Sticky load-timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      LdErr <= 1'b0;
    end else if (ld_timeout) begin
      LdErr <= 1'b1;
    end else if (ErrClr) begin
      LdErr <= 1'b0;
    end
  end

  // Debug counter of issued register writes, wrapping modulo 2**16.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RetireCnt <= '0;
    end else if (WriteEn) begin
      RetireCnt <= RetireCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random
// ALU/load traffic, compared against a transaction-level expectation model.
module tb_wb_stage;

  localparam int W       = 8;
  localparam int A       = 3;
  localparam int TIMEOUT = 16;

  logic         Clk;
  logic         Reset_n;
  logic         InValid;
  logic         InReady;
  logic [A-1:0] InDst;
  logic         InRegWrite;
  logic         InIsLoad;
  logic [W-1:0] InAluResult;
  logic         MemRdValid;
  logic [W-1:0] MemRdData;
  logic         WriteEn;
  logic [A-1:0] Waddr;
  logic [W-1:0] DataIn;
  logic         LdErr;
  logic         ErrClr;
  logic [15:0]  RetireCnt;

  wb_stage #(.W(W), .A(A), .TIMEOUT(TIMEOUT)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .InValid     (InValid),
    .InReady     (InReady),
    .InDst       (InDst),
    .InRegWrite  (InRegWrite),
    .InIsLoad    (InIsLoad),
    .InAluResult (InAluResult),
    .MemRdValid  (MemRdValid),
    .MemRdData   (MemRdData),
    .WriteEn     (WriteEn),
    .Waddr       (Waddr),
    .DataIn      (DataIn),
    .LdErr       (LdErr),
    .ErrClr      (ErrClr),
    .RetireCnt   (RetireCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected architectural view of the write port and debug outputs.
  int           n_checks = 0;
  int           n_fail   = 0;
  logic         exp_we;
  logic [A-1:0] exp_waddr;
  logic [W-1:0] exp_data;
  logic         exp_err;
  logic [15:0]  exp_cnt;
  logic         exp_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".WriteEn"},   32'(WriteEn),   32'(exp_we));
    check({tag, ".Waddr"},     32'(Waddr),     32'(exp_waddr));
    check({tag, ".DataIn"},    32'(DataIn),    32'(exp_data));
    check({tag, ".LdErr"},     32'(LdErr),     32'(exp_err));
    check({tag, ".RetireCnt"}, 32'(RetireCnt), 32'(exp_cnt));
    check({tag, ".InReady"},   32'(InReady),   32'(exp_ready));
  endtask

  task automatic model_reset();
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_data  = '0;
    exp_err   = 1'b0;
    exp_cnt   = '0;
    exp_ready = 1'b1;
  endtask

  // One clock edge: a write visible before the edge is counted at it, the
  // write enable becomes `we`, and a timeout sets the error over any clear.
  task automatic tick(input logic we, input logic timeout);
    @(posedge Clk);
    exp_cnt = exp_cnt + 16'(exp_we);
    exp_we  = we;
    if (timeout)     exp_err = 1'b1;
    else if (ErrClr) exp_err = 1'b0;
    #1;
  endtask

  task automatic idle(input string tag);
    InValid    = 1'b0;
    MemRdValid = 1'b0;
    tick(1'b0, 1'b0);
    check_all(tag);
  endtask

  task automatic do_alu(input logic [A-1:0] dst, input logic [W-1:0] data,
                        input logic rw, input string tag);
    InValid     = 1'b1;
    InIsLoad    = 1'b0;
    InDst       = dst;
    InAluResult = data;
    InRegWrite  = rw;
    tick(rw, 1'b0);
    if (rw) begin
      exp_waddr = dst;
      exp_data  = data;
    end
    check_all(tag);
    InValid = 1'b0;
  endtask

  // Load whose read data arrives in wait cycle `d` (1-based); a `d` past
  // TIMEOUT never delivers data. `junk` offers stale data on the accept edge,
  // `hold` keeps a follow-on ALU write (r6=0x3C) pending on InValid.
  task automatic do_load(input logic [A-1:0] dst, input logic rw, input int d,
                         input logic [W-1:0] data, input logic junk,
                         input logic clr_at_to, input logic hold, input string tag);
    InValid     = 1'b1;
    InIsLoad    = 1'b1;
    InDst       = dst;
    InRegWrite  = rw;
    InAluResult = W'($urandom);
    MemRdValid  = junk;
    MemRdData   = 8'h99;
    tick(1'b0, 1'b0);
    exp_ready = 1'b0;
    check_all({tag, ".acc"});
    MemRdValid = 1'b0;
    InIsLoad   = 1'b0;
    if (hold) begin
      InValid     = 1'b1;
      InDst       = 3'd6;
      InAluResult = 8'h3C;
      InRegWrite  = 1'b1;
    end else begin
      InValid = 1'b0;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (k == d) begin
        MemRdValid = 1'b1;
        MemRdData  = data;
        tick(rw, 1'b0);
        exp_waddr = dst;
        exp_data  = data;
        exp_ready = 1'b1;
        check_all({tag, ".done"});
        MemRdValid = 1'b0;
        break;
      end else if (k == TIMEOUT) begin
        ErrClr = clr_at_to;
        tick(1'b0, 1'b1);
        exp_ready = 1'b1;
        check_all({tag, ".timeout"});
        ErrClr = 1'b0;
      end else begin
        tick(1'b0, 1'b0);
        check_all({tag, ".wait"});
      end
    end
    if (hold) begin
      tick(1'b1, 1'b0);
      exp_waddr = 3'd6;
      exp_data  = 8'h3C;
      check_all({tag, ".follow"});
      InValid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n     = 1'b0;
    InValid     = 1'b0;
    InDst       = '0;
    InRegWrite  = 1'b0;
    InIsLoad    = 1'b0;
    InAluResult = '0;
    MemRdValid  = 1'b0;
    MemRdData   = '0;
    ErrClr      = 1'b0;
    model_reset();

    // Reset state.
    #2;
    check_all("reset");
    #10;
    Reset_n = 1'b1;
    idle("post_reset");

    // Single ALU write, one-cycle latency, counted on the next edge.
    do_alu(3'd3, 8'h5A, 1'b1, "alu_r3");
    idle("alu_r3_cnt");

    // Three back-to-back ALU writes.
    do_alu(3'd1, 8'h11, 1'b1, "b2b_r1");
    do_alu(3'd2, 8'h22, 1'b1, "b2b_r2");
    do_alu(3'd7, 8'hFF, 1'b1, "b2b_r7");
    idle("b2b_cnt");

    // ALU op without register write, and a write to r0.
    do_alu(3'd4, 8'hAB, 1'b0, "alu_nowr");
    do_alu(3'd0, 8'h01, 1'b1, "alu_r0");
    idle("alu_r0_cnt");

    // Load to r5 with data after 4 wait cycles; a held ALU op follows.
    do_load(3'd5, 1'b1, 4, 8'hC3, 1'b0, 1'b0, 1'b1, "ld_r5");
    idle("ld_r5_cnt");

    // Load that never gets data: timeout, error flag, clear.
    do_load(3'd2, 1'b1, TIMEOUT + 5, 8'h00, 1'b0, 1'b0, 1'b0, "ld_to1");
    ErrClr = 1'b1;
    idle("errclr");
    ErrClr = 1'b0;
    // Second timeout with a simultaneous clear: the error stays set.
    do_load(3'd2, 1'b1, TIMEOUT + 5, 8'h00, 1'b0, 1'b1, 1'b0, "ld_to2");
    idle("ld_to2_hold");
    // Data in the terminal-count cycle wins over the timeout.
    ErrClr = 1'b1;
    idle("errclr2");
    ErrClr = 1'b0;
    do_load(3'd1, 1'b1, TIMEOUT, 8'h5E, 1'b0, 1'b0, 1'b0, "ld_last");
    idle("ld_last_cnt");

    // Read data offered on the accept edge is ignored.
    do_load(3'd4, 1'b1, 3, 8'h44, 1'b1, 1'b0, 1'b0, "ld_junk");

    // Load without register write still retires no write.
    do_load(3'd7, 1'b0, 2, 8'h77, 1'b0, 1'b0, 1'b0, "ld_nowr");
    idle("ld_nowr_cnt");

    // Asynchronous reset in the middle of a load wait.
    InValid    = 1'b1;
    InIsLoad   = 1'b1;
    InDst      = 3'd6;
    InRegWrite = 1'b1;
    tick(1'b0, 1'b0);
    exp_ready = 1'b0;
    check_all("rst_ld_acc");
    InValid  = 1'b0;
    InIsLoad = 1'b0;
    tick(1'b0, 1'b0);
    check_all("rst_ld_wait");
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    MemRdValid = 1'b1;
    MemRdData  = 8'hE7;
    #2;
    Reset_n = 1'b1;
    tick(1'b0, 1'b0);
    check_all("rst_no_write");
    MemRdValid = 1'b0;
    idle("rst_idle");

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      int kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        do_alu(A'($urandom), W'($urandom), logic'($urandom_range(0, 3) != 0), "rnd_alu");
      end else if (kind < 8) begin
        do_load(A'($urandom), logic'($urandom_range(0, 3) != 0),
                int'($urandom_range(1, TIMEOUT + 4)), W'($urandom),
                logic'($urandom), logic'($urandom), 1'b0, "rnd_ld");
      end else begin
        ErrClr = logic'($urandom);
        idle("rnd_idle");
        ErrClr = 1'b0;
      end
    end
    idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
